// File: rtl/serv_pcgen.sv
// serv_pcgen: bit/digit-serial program counter generator.
//
// The PC lives in o_ibus_adr and is rotated right one W-bit digit per SHIFT
// cycle. The new digit enters at the top, so after N = 32/W cycles the whole
// register holds the new PC. Two serial adders share the cycle: one forms
// PC+2/PC+4 and the other forms the jump/branch/auipc target.
//
// Optional feature, macro SERV_PCGEN_MISALIGN_EN: when WITH_C=0, a jump whose
// aligned target has bit 1 set is flagged on o_misalign in DONE. The old PC,
// captured digit by digit into a shadow register, is then written back.
// With the macro undefined there is no shadow register and o_misalign is 0.

module serv_pcgen #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter bit          WITH_CSR = 1'b1,
    parameter bit          WITH_C   = 1'b1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_jump,
    input  logic         i_jal_or_jalr,
    input  logic         i_utype,
    input  logic         i_pc_rel,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic [W-1:0] i_imm,
    input  logic [W-1:0] i_buf,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic [W-1:0] o_bad_pc,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_misalign,
    output logic [31:0]  o_ibus_adr
);

    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);

    // Elaboration-time guard on the digit width.
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
        $error("serv_pcgen: W must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_first;
    logic            cnt_last;

    // Current PC digit. The register rotates right, so the digit under
    // processing is always at the bottom.
    logic [W-1:0]    pc;

    // Per-bit masks, derived from each bit's absolute position cnt*W + j.
    logic [W-1:0]    keep_imm;   // immediate bits 12..31 (U-type)
    logic [W-1:0]    keep_csr;   // trap vector bits 2..31
    logic [W-1:0]    keep_tgt;   // target bits 1..31
    logic [W-1:0]    inc_digit;  // 2 or 4 injected at its absolute position

    logic            carry_inc_q;
    logic            carry_off_q;
    logic            cin_inc;
    logic            cin_off;
    logic [W:0]      sum_inc;
    logic [W:0]      sum_off;
    logic [W-1:0]    pc_plus_4;
    logic [W-1:0]    offset_a;
    logic [W-1:0]    offset_b;
    logic [W-1:0]    aligned;
    logic [W-1:0]    trap_digit;
    logic            trap_en;
    logic [W-1:0]    new_pc;

    assign pc        = o_ibus_adr[W-1:0];
    assign cnt_first = (cnt == '0);
    assign cnt_last  = (cnt == CW'(N - 1));
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    // NOTE: the default assignment first keeps this block free of latches
    // on paths that do not name state_nxt explicitly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Digit counter: 0 on entry to SHIFT, steps once per SHIFT cycle.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (state == SHIFT && !cnt_last) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------

    // Position-dependent masks and the increment digit.
    always_comb begin
        keep_imm  = '0;
        keep_csr  = '0;
        keep_tgt  = '0;
        inc_digit = '0;
        for (int j = 0; j < W; j++) begin
            keep_imm[j]  = (int'(cnt) * W + j) >= 12;
            keep_csr[j]  = (int'(cnt) * W + j) >= 2;
            keep_tgt[j]  = (int'(cnt) * W + j) != 0;
            inc_digit[j] = (int'(cnt) * W + j) == (i_iscomp ? 1 : 2);
        end
    end

    // The carries from the previous word must not leak into digit 0, so the
    // carry-in is forced low on the first digit instead of clearing the flops.
    assign cin_inc    = cnt_first ? 1'b0 : carry_inc_q;
    assign cin_off    = cnt_first ? 1'b0 : carry_off_q;

    assign offset_a   = i_pc_rel ? pc : '0;
    assign offset_b   = i_utype ? (i_imm & keep_imm) : i_buf;

    assign sum_inc    = {1'b0, pc} + {1'b0, inc_digit} + (W + 1)'(cin_inc);
    assign sum_off    = {1'b0, offset_a} + {1'b0, offset_b} + (W + 1)'(cin_off);

    assign pc_plus_4  = sum_inc[W-1:0];
    assign aligned    = sum_off[W-1:0] & keep_tgt;
    assign trap_digit = i_csr_pc & keep_csr;
    assign trap_en    = WITH_CSR & i_trap;

    // Next PC digit: trap vector beats jump target beats sequential.
    always_comb begin
        new_pc = pc_plus_4;
        if (trap_en) begin
            new_pc = trap_digit;
        end else if (i_jump) begin
            new_pc = aligned;
        end
    end

    // Writeback and target digits.
    assign o_rd     = (i_utype ? aligned : '0) | (i_jal_or_jalr ? pc_plus_4 : '0);
    assign o_bad_pc = aligned;

    // Adder carries, carried between consecutive SHIFT digits. The carry out
    // of the last digit is simply overwritten later, so sums wrap at 2^32.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            carry_inc_q <= 1'b0;
            carry_off_q <= 1'b0;
        end else if (state == SHIFT) begin
            carry_inc_q <= sum_inc[W];
            carry_off_q <= sum_off[W];
        end
    end

`ifdef SERV_PCGEN_MISALIGN_EN
    // ------------------------------------------------------------------
    // Misaligned-jump detection and PC restore
    // ------------------------------------------------------------------

    logic [31:0]  shadow;
    logic         mis_det;
    logic [W-1:0] at_bit1;
    logic         mis_cand;

    // Marks the digit bit that holds absolute target bit 1.
    always_comb begin
        at_bit1 = '0;
        for (int j = 0; j < W; j++) begin
            at_bit1[j] = (int'(cnt) * W + j) == 1;
        end
    end

    assign mis_cand = !WITH_C && i_jump && !trap_en && (state == SHIFT) &&
                      |(aligned & at_bit1);

    // Shadow copy of the old PC and the misalign flag. The flag is raised
    // at the last SHIFT edge, so it is visible exactly in DONE.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            shadow     <= '0;
            mis_det    <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mis_det    <= 1'b0;
                    o_misalign <= 1'b0;
                end
                SHIFT: begin
                    shadow <= {pc, shadow[31:W]};
                    if (mis_cand) mis_det <= 1'b1;
                    if (cnt_last) o_misalign <= mis_det | mis_cand;
                end
                default: begin
                    o_misalign <= 1'b0;
                end
            endcase
        end
    end

    // PC register: rotate in new digits; in DONE, undo a misaligned jump.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_ibus_adr <= RESET_PC;
        end else if (state == SHIFT) begin
            o_ibus_adr <= {new_pc, o_ibus_adr[31:W]};
        end else if (state == DONE && o_misalign) begin
            o_ibus_adr <= shadow;
        end
    end
`else
    assign o_misalign = 1'b0;

    // PC register: rotate in one new digit per SHIFT cycle.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_ibus_adr <= RESET_PC;
        end else if (state == SHIFT) begin
            o_ibus_adr <= {new_pc, o_ibus_adr[31:W]};
        end
    end
`endif

endmodule

// File: tb/tb_serv_pcgen.sv
// Directed bench for serv_pcgen with W=4. dut_a uses the default
// configuration; dut_b has WITH_CSR=0 and WITH_C=0 and shares every input.
module tb_serv_pcgen;

    localparam int W = 4;
    localparam int N = 32 / W;
`ifdef SERV_PCGEN_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         jump = 1'b0, jal = 1'b0, utype = 1'b0, pcrel = 1'b0, trap = 1'b0, iscomp = 1'b0;
    logic [W-1:0] imm = '0, buf_d = '0, csr = '0;

    logic [W-1:0] rd_a, bad_a, rd_b, bad_b;
    logic         busy_a, done_a, mis_a, busy_b, done_b, mis_b;
    logic [31:0]  pc_a, pc_b;

    int checks = 0;
    int errors = 0;

    // Results of the last run_op.
    logic [31:0] r_rd, r_bad;
    int          r_busy, r_early_done, r_mis_shift;
    logic        r_done, r_mis_a, r_mis_b, r_idle_done, r_idle_busy, r_idle_mis;

    serv_pcgen #(.W(W), .RESET_PC(32'd0), .WITH_CSR(1'b1), .WITH_C(1'b1)) dut_a (
        .clk(clk), .i_rst(rst), .i_start(start), .i_jump(jump), .i_jal_or_jalr(jal),
        .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
        .i_imm(imm), .i_buf(buf_d), .i_csr_pc(csr), .o_rd(rd_a), .o_bad_pc(bad_a),
        .o_busy(busy_a), .o_done(done_a), .o_misalign(mis_a), .o_ibus_adr(pc_a)
    );

    serv_pcgen #(.W(W), .RESET_PC(32'd0), .WITH_CSR(1'b0), .WITH_C(1'b0)) dut_b (
        .clk(clk), .i_rst(rst), .i_start(start), .i_jump(jump), .i_jal_or_jalr(jal),
        .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
        .i_imm(imm), .i_buf(buf_d), .i_csr_pc(csr), .o_rd(rd_b), .o_bad_pc(bad_b),
        .o_busy(busy_b), .o_done(done_b), .o_misalign(mis_b), .o_ibus_adr(pc_b)
    );

    always #5 clk = ~clk;

    // One complete PC update; called from IDLE at a negative edge.
    task automatic run_op(input logic j, input logic jl, input logic u, input logic pr,
                          input logic tr, input logic ic, input logic [31:0] imm32,
                          input logic [31:0] buf32, input logic [31:0] csr32);
        jump = j; jal = jl; utype = u; pcrel = pr; trap = tr; iscomp = ic;
        imm = imm32[W-1:0]; buf_d = buf32[W-1:0]; csr = csr32[W-1:0];
        start = 1'b1;
        r_rd = '0; r_bad = '0; r_busy = 0; r_early_done = 0; r_mis_shift = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            imm = imm32[k*W +: W]; buf_d = buf32[k*W +: W]; csr = csr32[k*W +: W];
            @(negedge clk);
            if (busy_a) r_busy++;
            if (done_a) r_early_done++;
            if (mis_a || mis_b) r_mis_shift++;
            r_rd[k*W +: W]  = rd_a;
            r_bad[k*W +: W] = bad_a;
            @(posedge clk); #1;
        end
        @(negedge clk);
        if (busy_a) r_busy++;
        r_done = done_a; r_mis_a = mis_a; r_mis_b = mis_b;
        @(posedge clk); #1;
        jump = 0; jal = 0; utype = 0; pcrel = 0; trap = 0; iscomp = 0;
        imm = '0; buf_d = '0; csr = '0;
        @(negedge clk);
        r_idle_done = done_a; r_idle_busy = busy_a; r_idle_mis = mis_a | mis_b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc_a got %h want %h", pc_a, 32'h0); end
        checks++; if (pc_b !== 32'h0) begin errors++; $display("FAIL reset_pc_b got %h want %h", pc_b, 32'h0); end
        checks++; if ({busy_a, done_a, mis_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy_a, done_a, mis_a}); end
        checks++; if ({busy_b, done_b, mis_b} !== 3'b000) begin errors++; $display("FAIL reset_flags_b got %b want 000", {busy_b, done_b, mis_b}); end
        rst = 1'b0;
    endtask

    // Start is asserted right after reset release, so the first edge accepts it.
    task automatic test_sequential();
        run_op(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checks++; if (r_busy !== 9) begin errors++; $display("FAIL seq_busy_cycles got %0d want 9", r_busy); end
        checks++; if (r_early_done !== 0) begin errors++; $display("FAIL seq_early_done got %0d want 0", r_early_done); end
        checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL seq_done got %b want 1", r_done); end
        checks++; if ({r_idle_done, r_idle_busy} !== 2'b00) begin errors++; $display("FAIL seq_idle got %b want 00", {r_idle_done, r_idle_busy}); end
        checks++; if (pc_a !== 32'h4) begin errors++; $display("FAIL seq_pc got %h want %h", pc_a, 32'h4); end
        checks++; if (r_rd !== 32'h4) begin errors++; $display("FAIL seq_rd got %h want %h", r_rd, 32'h4); end
        checks++; if (pc_b !== 32'h4) begin errors++; $display("FAIL seq_pc_b got %h want %h", pc_b, 32'h4); end
    endtask

    task automatic test_wrap();
        run_op(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        checks++; if (pc_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setpc got %h want %h", pc_a, 32'hFFFF_FFFC); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL wrap_rd_zero got %h want %h", r_rd, 32'h0); end
        run_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want %h", pc_a, 32'h0); end
        run_op(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFE, 32'h0);
        checks++; if (pc_a !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_setpc2 got %h want %h", pc_a, 32'hFFFF_FFFE); end
        run_op(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL wrap_plus2 got %h want %h", pc_a, 32'h0); end
    endtask

    task automatic test_jump_rel();
        run_op(1, 0, 0, 0, 0, 0, 32'h0, 32'h100, 32'h0);
        checks++; if (pc_a !== 32'h100) begin errors++; $display("FAIL jrel_setpc got %h want %h", pc_a, 32'h100); end
        run_op(1, 0, 0, 1, 0, 0, 32'h0, 32'h101, 32'h0);
        checks++; if (pc_a !== 32'h200) begin errors++; $display("FAIL jrel_pc got %h want %h", pc_a, 32'h200); end
        checks++; if (r_bad !== 32'h200) begin errors++; $display("FAIL jrel_bad_pc got %h want %h", r_bad, 32'h200); end
        checks++; if (pc_b !== 32'h200) begin errors++; $display("FAIL jrel_pc_b got %h want %h", pc_b, 32'h200); end
        // jal-style: link value is the old PC + 4.
        run_op(1, 1, 0, 1, 0, 0, 32'h0, 32'h10, 32'h0);
        checks++; if (pc_a !== 32'h210) begin errors++; $display("FAIL jal_pc got %h want %h", pc_a, 32'h210); end
        checks++; if (r_rd !== 32'h204) begin errors++; $display("FAIL jal_rd got %h want %h", r_rd, 32'h204); end
    endtask

    task automatic test_trap();
        run_op(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h8000_0003);
        checks++; if (pc_a !== 32'h8000_0000) begin errors++; $display("FAIL trap_pc got %h want %h", pc_a, 32'h8000_0000); end
        checks++; if (pc_b !== 32'h214) begin errors++; $display("FAIL trap_nocsr_pc got %h want %h", pc_b, 32'h214); end
    endtask

    task automatic test_misalign();
        run_op(1, 0, 0, 0, 0, 0, 32'h0, 32'h100, 32'h0);
        run_op(1, 0, 0, 1, 0, 0, 32'h0, 32'h2, 32'h0);
        checks++; if (pc_a !== 32'h102) begin errors++; $display("FAIL mis_pc_c got %h want %h", pc_a, 32'h102); end
        checks++; if (r_mis_a !== 1'b0) begin errors++; $display("FAIL mis_flag_c got %b want 0", r_mis_a); end
        checks++; if (pc_b !== (MIS_EN ? 32'h100 : 32'h102)) begin errors++; $display("FAIL mis_pc_noc got %h want %h", pc_b, (MIS_EN ? 32'h100 : 32'h102)); end
        checks++; if (r_mis_b !== MIS_EN) begin errors++; $display("FAIL mis_flag_noc got %b want %b", r_mis_b, MIS_EN); end
        checks++; if (r_mis_shift !== 0) begin errors++; $display("FAIL mis_in_shift got %0d want 0", r_mis_shift); end
        checks++; if (r_idle_mis !== 1'b0) begin errors++; $display("FAIL mis_in_idle got %b want 0", r_idle_mis); end
    endtask

    // auipc-like: low 12 immediate bits are dropped before the add.
    task automatic test_utype();
        run_op(0, 0, 1, 1, 0, 0, 32'h1234_5FFF, 32'h0, 32'h0);
        checks++; if (r_rd !== 32'h1234_5102) begin errors++; $display("FAIL utype_rd got %h want %h", r_rd, 32'h1234_5102); end
        checks++; if (pc_a !== 32'h106) begin errors++; $display("FAIL utype_pc got %h want %h", pc_a, 32'h106); end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL abort_pc got %h want %h", pc_a, 32'h0); end
        checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL abort_busy got %b want 00", {busy_a, busy_b}); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_a || done_b) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_seen); end
        run_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checks++; if (pc_a !== 32'h4) begin errors++; $display("FAIL abort_resume got %h want %h", pc_a, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_jump_rel();
        test_trap();
        test_misalign();
        test_utype();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_pcgen.md
SERV_PCGEN -- requirements
Module: serv_pcgen

Interface
REQ-001 SHALL have parameter W, default 1: digit width in bits; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-003 SHALL have parameter WITH_CSR, default 1: 0 removes the trap path and i_trap is ignored.
REQ-004 SHALL have parameter WITH_C, default 1: 1 means compressed instructions are supported, so target bit 1 is legal.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: request one PC update; sampled only in IDLE.
REQ-008 SHALL have control ports i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp, each input, 1 bit; held stable from i_start until o_done.
REQ-009 SHALL have data ports i_imm, i_buf, i_csr_pc, each input, W bits: operand digits, LSB digit first, one digit per SHIFT cycle.
REQ-010 SHALL have output o_rd, W bits: rd writeback digit.
REQ-011 SHALL have output o_bad_pc, W bits: aligned target digit.
REQ-012 SHALL have output o_busy, 1 bit: high in SHIFT and DONE.
REQ-013 SHALL have output o_done, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have output o_misalign, 1 bit: misaligned-target flag.
REQ-015 SHALL have output o_ibus_adr, 32 bits: current PC.

Function
REQ-016 SHALL implement FSM IDLE->SHIFT on i_start; SHIFT->DONE after N=32/W cycles; DONE->IDLE after 1 cycle; i_start ignored outside IDLE.
REQ-017 SHALL keep an internal digit counter of log2(N) bits: 0 on SHIFT entry, +1 per SHIFT cycle, exit at N-1.
REQ-018 SHALL, on each SHIFT cycle, set o_ibus_adr <= {new_pc, o_ibus_adr[31:W]}; the PC is unchanged in IDLE and DONE (except REQ-026).
REQ-019 SHALL compute increment = 2 if i_iscomp else 4, injected at absolute bit position 1 or 2 (digit pos/W, bit pos%W); all other digits add 0.
REQ-020 SHALL compute pc_plus_4 and pc_plus_offset as W-bit adds plus a registered carry; both carries are forced to 0 on counter 0.
REQ-021 SHALL compute offset_a = pc if i_pc_rel else 0; offset_b = i_imm masked to bits 12..31 if i_utype else i_buf; aligned target = pc_plus_offset with absolute bit 0 forced to 0.
REQ-022 SHALL select new_pc: trap (WITH_CSR=1) -> i_csr_pc with absolute bits 1:0 forced 0; else jump -> aligned target; else pc_plus_4.
REQ-023 SHALL form o_rd = (aligned target if i_utype) OR (pc_plus_4 if i_jal_or_jalr), else 0; o_bad_pc = aligned target.
REQ-024 SHALL wrap all sums modulo 2^32, discarding the final carry.
REQ-025 SHALL assert o_done only in DONE.

Reset
REQ-026 SHALL, on i_rst, immediately (asynchronously) set o_ibus_adr=RESET_PC, FSM=IDLE, counter=0, carries=0, o_misalign=0, and shadow register=0, aborting any SHIFT in progress.
REQ-027 SHALL resume operation on the first rising edge of clk after i_rst deasserts; i_start sampled on that edge is accepted.

Configuration
REQ-028 SHALL provide macro SERV_PCGEN_MISALIGN_EN; when it is defined, the old PC is captured digit-by-digit into a 32-bit shadow register during SHIFT.
REQ-029 SHALL, with the macro defined, WITH_C=0, i_jump=1 and i_trap=0, detect aligned target bit 1 = 1; then o_misalign=1 in DONE (cleared on entering IDLE) and o_ibus_adr is restored from the shadow register in DONE.
REQ-030 SHALL, without the macro, have no shadow register, tie o_misalign to 0, and always commit new_pc.

Verification (W=4, RESET_PC=0)
REQ-031 SHALL cover: reset, then i_start with no jump and i_jal_or_jalr=1 -> o_busy for 9 cycles, o_done in cycle 9, o_ibus_adr=0x4, o_rd digits serialise 0x4.
REQ-032 SHALL cover: PC=0xFFFFFFFC, sequential update -> o_ibus_adr=0x00000000; with i_iscomp=1 from PC 0xFFFFFFFE -> 0x00000000.
REQ-033 SHALL cover: PC=0x100, i_jump=1, i_pc_rel=1, i_buf serial 0x101 -> o_ibus_adr=0x200, o_bad_pc serial 0x200.
REQ-034 SHALL cover: i_trap=1, i_csr_pc=0x80000003 -> o_ibus_adr=0x80000000; with WITH_CSR=0 -> o_ibus_adr=PC+4.
REQ-035 SHALL cover: macro defined, WITH_C=0, PC=0x100, target 0x102 -> o_misalign=1 in DONE, o_ibus_adr=0x100; without the macro -> o_ibus_adr=0x102, o_misalign=0.
REQ-036 SHALL cover: i_rst asserted at SHIFT counter 3 -> same cycle o_ibus_adr=0, o_busy=0, and no o_done pulse.
